// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch_ctrl_if: memory, redirect and decode-side signals of the fetch unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface inst_fetch_ctrl_if;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_error;

  modport master (
    output mem_addr,
    input  mem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc,
    output fetch_error
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc,
    input  fetch_error
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch_ctrl: byte-serial big-endian instruction fetch with 2-entry decode buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 512
) (
  input  wire logic         clock,
  input  wire logic         reset,
  inst_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_reg;
  logic [31:0] hold_word;
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic [31:0] tail_instr;
  logic [31:0] tail_pc;
  logic [1:0]  count;

  logic        pop;
  logic        push_ok;
  logic        push;
  logic        rd_byte;
  logic        latch_hold;
  logic        addr_ok;
  logic        wr_tail;
  logic [31:0] push_word;
  logic [32:0] end_addr;

  // 33-bit sum so a fetch_pc near 2^32 can never wrap back into range
  assign end_addr = {1'b0, fetch_pc} + 33'd4;
  assign addr_ok  = (end_addr <= 33'(MEM_BYTES));
  assign pop      = bus.inst_valid && bus.inst_ready;
  assign push_ok  = (count < 2'd2) || pop;
  assign wr_tail  = (count == 2'd2) || ((count == 2'd1) && !pop);

  assign bus.mem_addr    = fetch_pc + {30'd0, byte_cnt};
  assign bus.inst_valid  = (count != 2'd0);
  assign bus.inst_out    = head_instr;
  assign bus.inst_pc     = head_pc;
  assign bus.fetch_error = (state == ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    rd_byte    = 1'b0;
    latch_hold = 1'b0;
    push_word  = {asm_reg, bus.mem_rdata};
    case (state)
      FETCH: begin
        if ((byte_cnt == 2'd0) && !addr_ok) begin
          state_nxt = ERROR;
        end else if (byte_cnt != 2'd3) begin
          rd_byte = 1'b1;
        end else if (push_ok) begin
          push = 1'b1;
        end else begin
          latch_hold = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (push_ok) begin
          push      = 1'b1;
          push_word = hold_word;
          state_nxt = FETCH;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
    if (bus.redirect_valid) begin
      push       = 1'b0;
      rd_byte    = 1'b0;
      latch_hold = 1'b0;
      state_nxt  = (bus.redirect_pc[1:0] != 2'b00) ? ERROR : FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      byte_cnt   <= 2'd0;
      asm_reg    <= 24'd0;
      hold_word  <= 32'd0;
      head_instr <= 32'd0;
      head_pc    <= 32'd0;
      tail_instr <= 32'd0;
      tail_pc    <= 32'd0;
      count      <= 2'd0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      byte_cnt <= 2'd0;
      count    <= 2'd0;
    end else begin
      if (rd_byte) begin
        asm_reg  <= {asm_reg[15:0], bus.mem_rdata};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (latch_hold) begin
        hold_word <= {asm_reg, bus.mem_rdata};
      end
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        byte_cnt <= 2'd0;
      end
      if (pop) begin
        head_instr <= tail_instr;
        head_pc    <= tail_pc;
      end
      // a push landing in the head slot must win over the shift above
      if (push) begin
        if (wr_tail) begin
          tail_instr <= push_word;
          tail_pc    <= fetch_pc;
        end else begin
          head_instr <= push_word;
          head_pc    <= fetch_pc;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl: directed and randomized checks against a word-stream model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned MEM_BYTES = 512;

  logic clock = 1'b0;
  logic reset = 1'b1;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem [MEM_BYTES];
  int          total   = 0;
  int          bad     = 0;
  int          n_deliv = 0;
  logic [31:0] exp_pc  = RESET_PC;

  always_comb begin
    bus.mem_rdata = (bus.mem_addr < MEM_BYTES) ? mem[bus.mem_addr[8:0]] : 8'h00;
  end

  function automatic logic [7:0] rd(input logic [31:0] a);
    return (a < MEM_BYTES) ? mem[a[8:0]] : 8'h00;
  endfunction

  // Big-endian word as decode should see it: byte at the lowest address on top
  function automatic logic [31:0] word(input logic [31:0] a);
    return {rd(a), rd(a + 32'd1), rd(a + 32'd2), rd(a + 32'd3)};
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] a;
    a = 32'($urandom_range(0, 127)) << 2;
    case ($urandom_range(0, 7))
      0:       return a | 32'($urandom_range(1, 3));
      1:       return 32'h0000_01F8;
      2:       return 32'h0000_0200;
      3:       return 32'hFFFF_FFFC;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: score any transfer in this cycle against the expected
  // word stream, advance, then check the protocol rules that follow from it.
  task automatic cyc();
    logic        xfer, stall, redir, err_hold;
    logic [31:0] held_out, held_pc, rpc, addr_before;
    redir       = bus.redirect_valid && !reset;
    rpc         = bus.redirect_pc;
    xfer        = bus.inst_valid && bus.inst_ready && !reset;
    stall       = bus.inst_valid && !bus.inst_ready && !reset && !redir;
    err_hold    = bus.fetch_error && !reset && !redir;
    held_out    = bus.inst_out;
    held_pc     = bus.inst_pc;
    addr_before = bus.mem_addr;
    if (xfer) begin
      chk("xfer_pc", bus.inst_pc, exp_pc);
      chk("xfer_inst", bus.inst_out, word(exp_pc));
      chk1("xfer_in_range", ({1'b0, bus.inst_pc} + 33'd4) <= 33'(MEM_BYTES), 1'b1);
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (reset) exp_pc = RESET_PC;
    else if (redir) exp_pc = rpc;
    @(posedge clock);
    #1;
    bus.redirect_valid = 1'b0;
    if (stall) begin
      chk1("hold_valid", bus.inst_valid, 1'b1);
      chk("hold_inst", bus.inst_out, held_out);
      chk("hold_pc", bus.inst_pc, held_pc);
    end
    if (redir) begin
      chk1("redir_valid", bus.inst_valid, 1'b0);
      chk("redir_addr", bus.mem_addr, rpc);
      chk1("redir_err", bus.fetch_error, rpc[1:0] != 2'b00);
    end
    if (err_hold) begin
      chk1("err_sticky", bus.fetch_error, 1'b1);
      chk("err_addr", bus.mem_addr, addr_before);
    end
  endtask

  task automatic do_reset(input logic rdy);
    bus.inst_ready     = rdy;
    bus.redirect_valid = 1'b0;
    reset              = 1'b1;
    cyc();
    cyc();
    chk1("rst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst", bus.inst_out, 32'd0);
    chk("rst_pc", bus.inst_pc, 32'd0);
    chk1("rst_err", bus.fetch_error, 1'b0);
    chk("rst_addr", bus.mem_addr, RESET_PC);
    reset = 1'b0;
  endtask

  initial begin
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
    mem[0]  = 8'h01; mem[1]  = 8'h00; mem[2]  = 8'h40; mem[3]  = 8'h20;
    mem[16] = 8'h8C; mem[17] = 8'h08; mem[18] = 8'h00; mem[19] = 8'h00;

    // Straight-line fetch: four bytes per word, first word visible in cycle 4
    do_reset(1'b1);
    for (int c = 0; c <= 8; c++) begin
      chk("t1_addr", bus.mem_addr, 32'(c));
      chk1("t1_valid", bus.inst_valid, (c == 4) || (c == 8));
      if (c == 4) begin
        chk("t1_inst", bus.inst_out, 32'h0100_4020);
        chk("t1_pc", bus.inst_pc, 32'h0);
      end
      if (c == 8) chk("t1_pc2", bus.inst_pc, 32'h4);
      cyc();
    end

    // Backpressure: two buffered words, third held with mem_addr parked at 11
    do_reset(1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c >= 12) begin
        chk("t2_hold_addr", bus.mem_addr, 32'd11);
        chk1("t2_hold_valid", bus.inst_valid, 1'b1);
        chk("t2_hold_pc", bus.inst_pc, 32'h0);
      end
      cyc();
    end
    begin
      int n0;
      n0 = n_deliv;
      bus.inst_ready = 1'b1;
      cyc();
      chk("t2_resume_addr", bus.mem_addr, 32'd12);
      repeat (5) cyc();
      chk("t2_delivered", 32'(n_deliv - n0), 32'd4);
    end

    // Redirect mid-word with one word buffered: both are discarded
    do_reset(1'b0);
    repeat (6) cyc();
    chk("t3_pre_addr", bus.mem_addr, 32'd6);
    chk1("t3_pre_valid", bus.inst_valid, 1'b1);
    bus.redirect_pc    = 32'h38;
    bus.redirect_valid = 1'b1;
    cyc();
    for (int c = 7; c <= 10; c++) begin
      chk1("t3_gap_valid", bus.inst_valid, 1'b0);
      cyc();
    end
    chk1("t3_valid", bus.inst_valid, 1'b1);
    chk("t3_pc", bus.inst_pc, 32'h38);
    chk("t3_inst", bus.inst_out, word(32'h38));
    bus.inst_ready = 1'b1;
    cyc();

    // Misaligned redirect latches the error; an aligned one clears it
    bus.redirect_pc    = 32'h3A;
    bus.redirect_valid = 1'b1;
    cyc();
    repeat (5) begin
      chk1("t4_err", bus.fetch_error, 1'b1);
      chk1("t4_valid", bus.inst_valid, 1'b0);
      chk("t4_addr", bus.mem_addr, 32'h3A);
      cyc();
    end
    bus.redirect_pc    = 32'h10;
    bus.redirect_valid = 1'b1;
    cyc();
    repeat (4) cyc();
    chk1("t4_rec_valid", bus.inst_valid, 1'b1);
    chk("t4_rec_pc", bus.inst_pc, 32'h10);
    chk("t4_rec_inst", bus.inst_out, 32'h8C08_0000);

    // Last words of memory, then the range check halts fetch at 0x200
    bus.inst_ready     = 1'b0;
    bus.redirect_pc    = 32'h1F8;
    bus.redirect_valid = 1'b1;
    cyc();
    repeat (9) cyc();
    chk1("t5_err", bus.fetch_error, 1'b1);
    chk("t5_addr", bus.mem_addr, 32'h200);
    chk1("t5_valid", bus.inst_valid, 1'b1);
    chk("t5_pc", bus.inst_pc, 32'h1F8);
    bus.inst_ready = 1'b1;
    cyc();
    chk("t5_pc2", bus.inst_pc, 32'h1FC);
    chk("t5_inst2", bus.inst_out, word(32'h1FC));
    cyc();
    chk1("t5_drained", bus.inst_valid, 1'b0);
    chk1("t5_err2", bus.fetch_error, 1'b1);
    chk("t5_addr2", bus.mem_addr, 32'h200);

    // Reset in HOLD with a full buffer, alongside a redirect that must lose
    do_reset(1'b0);
    repeat (13) cyc();
    chk("t6_hold_addr", bus.mem_addr, 32'd11);
    chk1("t6_full_valid", bus.inst_valid, 1'b1);
    reset              = 1'b1;
    bus.redirect_pc    = 32'h3A;
    bus.redirect_valid = 1'b1;
    cyc();
    chk1("t6_valid", bus.inst_valid, 1'b0);
    chk1("t6_err", bus.fetch_error, 1'b0);
    chk("t6_addr", bus.mem_addr, RESET_PC);
    chk("t6_inst", bus.inst_out, 32'd0);
    chk("t6_pc", bus.inst_pc, 32'd0);
    reset          = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (4) cyc();
    chk1("t6_restart_valid", bus.inst_valid, 1'b1);
    chk("t6_restart_pc", bus.inst_pc, RESET_PC);
    chk("t6_restart_inst", bus.inst_out, 32'h0100_4020);

    // Random readiness and redirects, scored against the word stream
    for (int k = 0; k < 2500; k++) begin
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        bus.redirect_pc    = pick_target();
        bus.redirect_valid = 1'b1;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the byte-wide instruction memory. Each cycle it drives one byte address, assembles four consecutive bytes into a big-endian 32-bit instruction, and queues the result with its PC in a 2-entry buffer for decode. Decode consumes from the buffer over a valid/ready handshake. The block also handles branch/jump redirects and flags illegal fetch addresses. It sits between the PC logic and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset; must be word-aligned.
MEM_BYTES, 512, instruction memory size in bytes; used for range checking.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
mem_addr  output  32  byte address to instruction memory; combinational, equals fetch_pc + byte_cnt.
mem_rdata  input  8  byte returned by instruction memory; combinational read, valid in the same cycle as mem_addr.
redirect_valid  input  1  one-cycle pulse: restart fetching at redirect_pc.
redirect_pc  input  32  new fetch address.
inst_valid  output  1  head buffer entry is valid.
inst_ready  input  1  decode accepts the head entry.
inst_out  output  32  head instruction, big-endian: byte at PC goes to [31:24].
inst_pc  output  32  byte address of inst_out.
fetch_error  output  1  sticky; fetching halted because of a misaligned or out-of-range address.

Behaviour:
- State: fetch_pc[31:0], byte_cnt[1:0], asm_reg[23:0], FSM {FETCH, HOLD, ERROR}, 2-entry buffer {instr, pc} with count 0..2.
- Reset: fetch_pc = RESET_PC, byte_cnt = 0, FSM = FETCH, buffer empty, inst_valid = 0, inst_out = 0, inst_pc = 0, fetch_error = 0. mem_addr therefore equals RESET_PC.
- Definition: push_ok = (count < 2) OR (inst_valid AND inst_ready).
- FETCH, byte_cnt 0..2: asm_reg = {asm_reg[15:0], mem_rdata}, then byte_cnt increments.
- FETCH, byte_cnt 3:
  - If push_ok: push {asm_reg, mem_rdata} with pc = fetch_pc, set fetch_pc += 4, byte_cnt = 0.
  - Otherwise: latch the full word and go to HOLD.
- HOLD: mem_addr stays at fetch_pc+3. When push_ok, push the held word, set fetch_pc += 4, byte_cnt = 0, return to FETCH.
- Address check, done before byte 0 of every word: if fetch_pc + 4 > MEM_BYTES, enter ERROR.
- ERROR:
  - fetch_error = 1; no memory reads progress and nothing is pushed.
  - The buffer still drains to decode.
  - Only a redirect or reset leaves ERROR.
- Throughput: one instruction per 4 cycles. First inst_valid is asserted in cycle 4 after reset deasserts (bytes read in cycles 0-3).
- Buffer:
  - FIFO order.
  - Pop occurs when inst_valid AND inst_ready.
  - Push and pop in the same cycle are both legal, including when count = 2.
  - inst_out/inst_pc are registered from the head entry and hold stable while inst_valid = 1 and inst_ready = 0.
- Redirect (highest priority, any state):
  - Flush the buffer, discard the partial or held word, set byte_cnt = 0, fetch_pc = redirect_pc.
  - inst_valid = 0 in the next cycle.
  - A pop in the redirect cycle still counts as a completed transfer.
  - A push that would occur in the redirect cycle is dropped.
  - If redirect_pc[1:0] != 0, enter ERROR instead.
  - If redirect_pc is aligned, clear fetch_error and go to FETCH.
- Wrap-around: fetch_pc uses 32-bit arithmetic. Overflow is covered by the range check and never wraps silently into valid memory.
- Reset mid-operation overrides everything, including a redirect in the same cycle.

Test Plan:
- Reset with RESET_PC = 0, memory bytes 0-3 = 01,00,40,20, inst_ready = 1 -> mem_addr steps 0,1,2,3; cycle 4 shows inst_valid = 1, inst_out = 32'h01004020, inst_pc = 0; next instruction (bytes 4-7) appears 4 cycles later with inst_pc = 4.
- Backpressure: inst_ready = 0 for 20 cycles -> buffer holds PC 0 and 4; the third word sits in HOLD with mem_addr = 11 steady. Raise inst_ready -> words for PC 0, 4, 8 are delivered in order with none lost or duplicated.
- Redirect to 32'h38 while byte_cnt = 2 -> next cycle inst_valid = 0 and mem_addr = 38; 4 cycles later inst_pc = 38; the partial word is never delivered.
- Redirect to 32'h3A -> fetch_error = 1 and no valid output. Then redirect to 32'h10 -> fetch_error clears and the instruction at 10 (8C080000) is delivered.
- With MEM_BYTES = 512, redirect to 32'h1FC -> word at 1FC is delivered. fetch_pc = 200 then enters ERROR: fetch_error = 1, mem_addr stays 200, and the remaining buffer entries still drain.
- Assert reset while HOLD and the buffer is full -> next cycle inst_valid = 0, fetch_error = 0, mem_addr = RESET_PC; normal sequence restarts after reset deasserts.
